// File: rtl/text_fetch_sched.sv
// Text-mode fetch scheduler: reads one {color,char} cell ahead of the beam from a
// single-port text RAM, shares that port with a host write path and overlays a
// blinking cursor on the fetched cell.
// Latency: RAM read at cx==5, data captured at cx==6, shown from cx==0 of the next cell.
// Backpressure: display fetch has fixed priority; o_wr_ready drops only in a fetch
// cycle, so a host request waits at most one cycle.
//
// Ports:
//   i_clk, i_rst_n         pixel clock, async active-low reset
//   i_x, i_y               beam position from the timing generator
//   i_cursor_en/_addr      cursor overlay enable and cell address
//   i_wr_valid/_addr/_data host write request; o_wr_ready accepts it
//   o_ram_en/_we/_addr/_wdata, i_ram_rdata   single-port text RAM interface
//   o_char, o_color        glyph index and palette select for the current cell
module text_fetch_sched #(
  parameter int COLS         = 80,
  parameter int ROWS         = 60,
  parameter int H_TOTAL      = 800,
  parameter int V_TOTAL      = 525,
  parameter int ADDR_W       = 13,
  parameter int BLINK_FRAMES = 30
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [10:0]       i_x,
  input  logic [10:0]       i_y,
  input  logic              i_cursor_en,
  input  logic [ADDR_W-1:0] i_cursor_addr,
  input  logic              i_wr_valid,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [6:0]        i_wr_data,
  output logic              o_wr_ready,
  output logic              o_ram_en,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [6:0]        o_ram_wdata,
  input  logic [6:0]        i_ram_rdata,
  output logic [4:0]        o_char,
  output logic [1:0]        o_color
);

  localparam logic [6:0] BLANK    = 7'b11_00000;
  localparam int         CELLS    = COLS * ROWS;
  // Last cell of the whole line (blanking included); its slot prefetches cell 0 of the next line.
  localparam logic [7:0] LAST_COL = 8'(H_TOTAL / 8 - 1);
  // Cells up to COLS-2 prefetch a visible successor; COLS-1 has none on this line.
  localparam logic [7:0] LAST_SRC = 8'(COLS - 1);
  localparam int         FC_W     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [7:0]        col;
  logic [2:0]        cx;
  logic              slot;
  logic              fetch;
  logic [7:0]        tcol;
  logic [10:0]       tline;
  logic [7:0]        trow;
  logic [ADDR_W-1:0] fetch_addr;
  logic              cursor_hit;
  logic              wr_in_range;

  logic              fetch_d;
  logic              hit_d;
  logic [6:0]        pend;
  logic [FC_W-1:0]   frame_cnt;
  logic              blink_phase;

  assign col = i_x[10:3];
  assign cx  = i_x[2:0];

  // Target cell of the fetch slot in this cell period.
  always_comb begin
    tcol  = 8'd0;
    tline = i_y;
    if (col == LAST_COL) begin
      tcol  = 8'd0;
      tline = (i_y == 11'(V_TOTAL - 1)) ? 11'd0 : i_y + 11'd1;
    end else begin
      tcol  = col + 8'd1;
      tline = i_y;
    end
    trow       = tline[10:3];
    slot       = (cx == 3'd5) && ((col < LAST_SRC) || (col == LAST_COL));
    fetch      = slot && (trow < 8'(ROWS));
    fetch_addr = ADDR_W'(trow) * ADDR_W'(COLS) + ADDR_W'(tcol);
  end

  assign cursor_hit  = i_cursor_en && (fetch_addr == i_cursor_addr) && blink_phase;
  assign wr_in_range = (32'(i_wr_addr) < 32'(CELLS));

  // RAM port arbitration: a display fetch owns the port; every other cycle belongs to the host.
  // Out-of-range host writes still handshake but never reach the RAM.
  always_comb begin
    o_wr_ready  = 1'b1;
    o_ram_en    = 1'b0;
    o_ram_we    = 1'b0;
    o_ram_addr  = i_wr_addr;
    o_ram_wdata = i_wr_data;
    if (fetch) begin
      o_wr_ready  = 1'b0;
      o_ram_en    = 1'b1;
      o_ram_we    = 1'b0;
      o_ram_addr  = fetch_addr;
      o_ram_wdata = '0;
    end else begin
      o_ram_en = i_wr_valid && wr_in_range;
      o_ram_we = i_wr_valid && wr_in_range;
    end
  end

  // Three-stage cell pipeline: issue (cx5) -> capture (cx6) -> present (cx7 edge).
  // pend resets to blank so nothing but blank reaches the output until a real fetch drains through.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fetch_d <= 1'b0;
      hit_d   <= 1'b0;
      pend    <= BLANK;
      o_char  <= 5'd0;
      o_color <= 2'b11;
    end else begin
      if (cx == 3'd5) begin
        fetch_d <= fetch;
        hit_d   <= fetch && cursor_hit;
      end
      if (cx == 3'd6) begin
        if (fetch_d)
          pend <= hit_d ? {2'b01, i_ram_rdata[4:0]} : i_ram_rdata;
        else
          pend <= BLANK;
      end
      if (cx == 3'd7) begin
        {o_color, o_char} <= pend;
      end
    end
  end

  // Blink timebase: one tick per frame at the top-left pixel.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if ((i_x == 11'd0) && (i_y == 11'd0)) begin
      if (frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

endmodule
